opc_mem_responder: RTL and testbench

OPC_MEM_RESPONDER -- requirements
Module: opc_mem_responder

---
 rtl/opc_mem_responder.sv | 142 ++++++++++++++
 tb/tb_opc_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/opc_mem_responder.sv
// Memory responder for a small CPU: a byte RAM split into a data region and a
// program region on the CPU bus, plus a loader port that fills the RAM while
// the CPU is held in reset and then releases it (cpu_run).
module opc_mem_responder #(
  parameter logic [10:0] DATA_BASE  = 11'h000,
  parameter int unsigned DATA_DEPTH = 16,
  parameter logic [10:0] PROG_BASE  = 11'h100,
  parameter int unsigned PROG_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] bus_addr,
  input  logic        bus_rnw,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [1:0]  ld_cmd,
  input  logic [7:0]  ld_data,
  output logic        cpu_run,
  output logic [5:0]  ld_ptr
);

  localparam int unsigned TOTAL = DATA_DEPTH + PROG_DEPTH;
  localparam int unsigned IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_BUSY = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_SETPTR = 2'd0,
    CMD_WRITE  = 2'd1,
    CMD_RUN    = 2'd2,
    CMD_HALT   = 2'd3
  } cmd_e;

  state_e        state_q, state_d;
  logic [5:0]    ptr_q, ptr_d;
  logic [7:0]    mem_q [TOTAL];

  cmd_e          cmd;
  logic [10:0]   data_off, prog_off;
  logic          data_hit, prog_hit, bus_hit;
  logic [IW-1:0] bus_idx;
  logic          ptr_in_range;
  logic          ld_we, cpu_we, mem_we;
  logic [IW-1:0] mem_widx;
  logic [7:0]    mem_wdata;

  assign cmd = cmd_e'(ld_cmd);

  // Bus address decode into a linear storage index; offsets below a region
  // base wrap to large unsigned values and so fall outside the region.
  always_comb begin
    data_off = bus_addr - DATA_BASE;
    prog_off = bus_addr - PROG_BASE;
    data_hit = (data_off < 11'(DATA_DEPTH));
    prog_hit = (prog_off < 11'(PROG_DEPTH));
    bus_hit  = data_hit | prog_hit;
    bus_idx  = '0;
    if (data_hit) begin
      bus_idx = IW'(data_off);
    end else if (prog_hit) begin
      bus_idx = IW'(prog_off + 11'(DATA_DEPTH));
    end
  end

  // Zero-latency read path; unmapped addresses return zero.
  always_comb begin
    bus_rdata = '0;
    if (bus_hit) begin
      bus_rdata = mem_q[bus_idx];
    end
  end

  // Loader FSM next state, pointer update and loader write request.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ld_we        = 1'b0;
    ptr_in_range = (32'(ptr_q) < TOTAL);
    case (state_q)
      ST_HALT: begin
        if (ld_valid) begin
          case (cmd)
            CMD_SETPTR: ptr_d = ld_data[5:0];
            CMD_WRITE: begin
              ld_we   = ptr_in_range;
              ptr_d   = ptr_q + 6'd1;
              state_d = ST_BUSY;
            end
            CMD_RUN:  state_d = ST_RUN;
            default:  state_d = ST_HALT;
          endcase
        end
      end
      ST_BUSY: state_d = ST_HALT;
      ST_RUN: begin
        if (ld_valid && (cmd == CMD_HALT)) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign cpu_run  = (state_q == ST_RUN);
  assign ld_ready = (state_q != ST_BUSY);
  assign ld_ptr   = ptr_q;

  // Single write port: loader writes only in HALT, CPU writes only in RUN, so
  // cpu_run alone selects the source. Gating with rst keeps an edge that lands
  // while reset is held from writing anything.
  always_comb begin
    cpu_we    = cpu_run & ~bus_rnw & bus_hit;
    mem_we    = (ld_we | cpu_we) & ~rst;
    mem_widx  = cpu_run ? bus_idx : ptr_q[IW-1:0];
    mem_wdata = cpu_run ? bus_wdata : ld_data;
  end

  // FSM state and loader pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HALT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array; deliberately not reset so contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_opc_mem_responder.sv
// Bench for opc_mem_responder: bus-address-level memory model plus a
// per-cycle compare process and directed literal checks.
module tb_opc_mem_responder;

  logic        clk;
  logic        rst;
  logic [10:0] bus_addr;
  logic        bus_rnw;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [1:0]  ld_cmd;
  logic [7:0]  ld_data;
  logic        cpu_run;
  logic [5:0]  ld_ptr;

  int checks   = 0;
  int failures = 0;
  bit done     = 0;

  // Model state: memory keyed by CPU bus address, loader mode, pointer.
  logic [7:0] mem_m [int];
  bit m_run  = 0;
  bit m_busy = 0;
  int m_ptr  = 0;

  opc_mem_responder #(
    .DATA_BASE (11'h000),
    .DATA_DEPTH(16),
    .PROG_BASE (11'h100),
    .PROG_DEPTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_addr (bus_addr),
    .bus_rnw  (bus_rnw),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_cmd   (ld_cmd),
    .ld_data  (ld_data),
    .cpu_run  (cpu_run),
    .ld_ptr   (ld_ptr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int idx2addr(input int i);
    return (i < 16) ? (32'h000 + i) : (32'h100 + (i - 16));
  endfunction

  function automatic bit mapped(input int a);
    return (a < 16) || (a >= 32'h100 && a < 32'h120);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules for one rising edge using the inputs present at that edge.
  task automatic model_update();
    int a;
    a = int'(bus_addr);
    if (rst) begin
      m_run = 0; m_busy = 0; m_ptr = 0;
    end else if (m_busy) begin
      m_busy = 0;
    end else if (m_run) begin
      if (!bus_rnw && mapped(a)) mem_m[a] = bus_wdata;
      if (ld_valid && ld_cmd == 2'd3) m_run = 0;
    end else if (ld_valid) begin
      case (ld_cmd)
        2'd0: m_ptr = int'(ld_data) % 64;
        2'd1: begin
          if (m_ptr < 48) mem_m[idx2addr(m_ptr)] = ld_data;
          m_ptr  = (m_ptr + 1) % 64;
          m_busy = 1;
        end
        2'd2: m_run = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a loader command and hold it until accepted, within a cycle budget.
  task automatic ld_send(input logic [1:0] c, input logic [7:0] d);
    bit sent;
    sent     = 0;
    ld_valid = 1;
    ld_cmd   = c;
    ld_data  = d;
    for (int k = 0; k < 8 && !sent; k++) begin
      if (ld_ready) sent = 1;
      step();
    end
    ld_valid = 0;
    chk("ld_accept", 32'(sent), 32'd1);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_rnw   = 0;
    bus_wdata = d;
    step();
    bus_rnw   = 1;
  endtask

  task automatic rd_chk(input string name, input logic [10:0] a, input logic [7:0] exp);
    bus_addr = a;
    #1;
    chk(name, 32'(bus_rdata), 32'(exp));
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    int a;
    while (!done) begin
      @(posedge clk);
      #2;
      chk("cpu_run", 32'(cpu_run), 32'(m_run));
      chk("ld_ready", 32'(ld_ready), 32'(!m_busy));
      chk("ld_ptr", 32'(ld_ptr), 32'(m_ptr));
      a = int'(bus_addr);
      if (!mapped(a)) chk("rdata_unmapped", 32'(bus_rdata), 32'd0);
      else if (mem_m.exists(a)) chk("rdata", 32'(bus_rdata), 32'(mem_m[a]));
    end
  end

  initial begin
    rst = 1; bus_addr = '0; bus_rnw = 1; bus_wdata = '0;
    ld_valid = 0; ld_cmd = '0; ld_data = '0;
    step();
    step();
    chk("reset_ready", 32'(ld_ready), 32'd1);
    chk("reset_run", 32'(cpu_run), 32'd0);
    chk("reset_ptr", 32'(ld_ptr), 32'd0);
    rst = 0;

    // Load then read back from the program region.
    ld_send(2'd0, 8'd16);
    ld_send(2'd1, 8'h0B);
    chk("busy_after_wr1", 32'(ld_ready), 32'd0);
    ld_send(2'd1, 8'hFF);
    chk("busy_after_wr2", 32'(ld_ready), 32'd0);
    idle(1);
    chk("ready_after_busy", 32'(ld_ready), 32'd1);
    rd_chk("rd_100", 11'h100, 8'h0B);
    rd_chk("rd_101", 11'h101, 8'hFF);
    chk("ptr_18", 32'(ld_ptr), 32'd18);

    // Release the CPU and exercise bus writes, including region boundaries.
    ld_send(2'd0, 8'd3);
    ld_send(2'd2, 8'h00);
    chk("run_set", 32'(cpu_run), 32'd1);
    cpu_write(11'h003, 8'h77);
    rd_chk("rd_003", 11'h003, 8'h77);
    cpu_write(11'h11F, 8'hC3);
    cpu_write(11'h050, 8'h5A);
    cpu_write(11'h010, 8'h3C);
    rd_chk("rd_050", 11'h050, 8'h00);
    rd_chk("rd_120", 11'h120, 8'h00);
    rd_chk("rd_010", 11'h010, 8'h00);
    rd_chk("rd_11f", 11'h11F, 8'hC3);

    // Non-HALT loader commands in RUN are swallowed.
    ld_send(2'd1, 8'hEE);
    chk("run_wr_ptr", 32'(ld_ptr), 32'd3);
    rd_chk("run_wr_mem", 11'h003, 8'h77);
    ld_send(2'd0, 8'd9);
    chk("run_setptr", 32'(ld_ptr), 32'd3);
    ld_send(2'd2, 8'h00);
    chk("run_run", 32'(cpu_run), 32'd1);

    // HALT coinciding with a CPU write: the write still lands.
    bus_addr = 11'h000; bus_rnw = 0; bus_wdata = 8'h99;
    ld_send(2'd3, 8'h00);
    bus_rnw = 1;
    chk("halt_run", 32'(cpu_run), 32'd0);
    rd_chk("halt_wr", 11'h000, 8'h99);

    // CPU bus writes are ignored while halted.
    cpu_write(11'h003, 8'h55);
    rd_chk("halt_cpu_wr", 11'h003, 8'h77);

    // Pointer bounds and wrap.
    ld_send(2'd0, 8'd63);
    ld_send(2'd1, 8'h11);
    chk("ptr_wrap0", 32'(ld_ptr), 32'd0);
    ld_send(2'd1, 8'h11);
    idle(1);
    chk("ptr_1", 32'(ld_ptr), 32'd1);
    rd_chk("rd_000_wrap", 11'h000, 8'h11);

    // Asynchronous reset mid-RUN, with a CPU write pending at the next edge.
    ld_send(2'd2, 8'h00);
    idle(1);
    bus_addr = 11'h003; bus_rnw = 1;
    #2;
    rst = 1; bus_rnw = 0; bus_wdata = 8'hAA;
    m_run = 0; m_busy = 0; m_ptr = 0;
    #1;
    chk("arst_run", 32'(cpu_run), 32'd0);
    chk("arst_ptr", 32'(ld_ptr), 32'd0);
    chk("arst_ready", 32'(ld_ready), 32'd1);
    step();
    rst = 0; bus_rnw = 1;
    rd_chk("arst_003", 11'h003, 8'h77);
    rd_chk("arst_100", 11'h100, 8'h0B);
    rd_chk("arst_101", 11'h101, 8'hFF);
    rd_chk("arst_000", 11'h000, 8'h11);
    ld_send(2'd0, 8'd5);
    chk("post_rst_cmd", 32'(ld_ptr), 32'd5);

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
